// File: rtl/filter_arb_pkg.sv
// Shared types and constants for the two-requester filter stream arbiter.
package filter_arb_pkg;

    localparam int unsigned NREQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Bits needed to hold any count in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/filter_arb_rr.sv
// Two-way round-robin picker: on contention the requester that did not win last time gets the grant.
module filter_arb_rr
    import filter_arb_pkg::*;
(
    input  logic [NREQ-1:0] eligible,
    input  logic            rr_last,
    output logic [NREQ-1:0] pick
);

    always_comb begin
        pick = '0;
        if (eligible[0] && eligible[1]) begin
            pick = rr_last ? 2'b01 : 2'b10;
        end else begin
            pick = eligible;
        end
    end

endmodule

// File: rtl/filter_stream_arbiter.sv
// Shares one HLS filter core between two requester FIFO pairs with burst round-robin grants.
// Optional per-requester statistics counters are enabled by defining FILTER_ARB_STATS_EN.
module filter_stream_arbiter
    import filter_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN     = 64,
    parameter int unsigned IDLE_TIMEOUT  = 16,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic                 bus_clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_open,
    input  logic [NREQ*32-1:0]   req_in_data,
    input  logic [NREQ-1:0]      req_in_empty,
    output logic [NREQ-1:0]      req_in_rden,
    output logic [31:0]          req_out_data,
    input  logic [NREQ-1:0]      req_out_full,
    output logic [NREQ-1:0]      req_out_wren,
    output logic [31:0]          filter_inp_dout,
    output logic                 filter_inp_empty_n,
    input  logic                 filter_inp_read,
    input  logic [31:0]          filter_outp_din,
    output logic                 filter_outp_full_n,
    input  logic                 filter_outp_write,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 err
`ifdef FILTER_ARB_STATS_EN
    ,
    output logic [NREQ*32-1:0]   stat_words,
    output logic [NREQ*16-1:0]   stat_grants
`endif
);

    localparam int unsigned CW = cnt_width(BURST_LEN);
    localparam int unsigned IW = cnt_width(IDLE_TIMEOUT);
    localparam int unsigned DW = cnt_width(DRAIN_TIMEOUT);

    localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_TIMEOUT);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            rr_last_q, rr_last_d;
    logic [CW-1:0]   issued_q, issued_d;
    logic [CW-1:0]   returned_q, returned_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick;
    logic            owner;
    logic            rd_ok;
    logic            wr_ok;

    assign eligible = req_open & ~req_in_empty;
    assign owner    = grant_q[1];

    filter_arb_rr u_rr (
        .eligible (eligible),
        .rr_last  (rr_last_q),
        .pick     (pick)
    );

    assign filter_inp_dout = owner ? req_in_data[63:32] : req_in_data[31:0];
    assign req_out_data    = filter_outp_din;
    assign grant           = grant_q;
    assign busy            = (state_q != IDLE);
    assign err             = err_q;

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_last_q  <= 1'b1;
            issued_q   <= '0;
            returned_q <= '0;
            idle_q     <= '0;
            drain_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            idle_q     <= idle_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        rr_last_d          = rr_last_q;
        issued_d           = issued_q;
        returned_d         = returned_q;
        idle_d             = idle_q;
        drain_d            = drain_q;
        err_d              = err_q;
        filter_inp_empty_n = 1'b0;
        filter_outp_full_n = 1'b0;
        req_in_rden        = '0;
        req_out_wren       = '0;
        rd_ok              = 1'b0;
        wr_ok              = 1'b0;

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    grant_d    = pick;
                    state_d    = FEED;
                    issued_d   = '0;
                    returned_d = '0;
                    idle_d     = '0;
                end
                if (filter_outp_write) begin
                    err_d = 1'b1;
                end
            end
            FEED: begin
                filter_inp_empty_n = !req_in_empty[owner] && (issued_q < BURST_MAX);
                rd_ok              = filter_inp_read && filter_inp_empty_n;
                req_in_rden[owner] = rd_ok;
                if (rd_ok) begin
                    issued_d = issued_q + CW'(1);
                end
                idle_d = req_in_empty[owner] ? idle_q + IW'(1) : '0;
                if ((issued_d == BURST_MAX) || (idle_d == IDLE_MAX) || !req_open[owner]) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (returned_q == issued_q) begin
                    state_d   = IDLE;
                    rr_last_d = owner;
                    grant_d   = '0;
                end else if (drain_d == DRAIN_MAX) begin
                    err_d     = 1'b1;
                    state_d   = IDLE;
                    rr_last_d = owner;
                    grant_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Results go only to the owner; a write beyond the words issued is flagged and dropped.
        if (state_q != IDLE) begin
            filter_outp_full_n = !req_out_full[owner];
            wr_ok              = filter_outp_write && filter_outp_full_n;
            if (wr_ok) begin
                if (returned_q < issued_d) begin
                    req_out_wren[owner] = 1'b1;
                    returned_d          = returned_q + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

`ifdef FILTER_ARB_STATS_EN
    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            stat_words  <= '0;
            stat_grants <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_out_wren[i]) begin
                    stat_words[32*i +: 32] <= stat_words[32*i +: 32] + 32'd1;
                end
                if ((state_q == IDLE) && (|eligible) && pick[i] && (stat_grants[16*i +: 16] != '1)) begin
                    stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/filter_stream_arbiter.md
Name: filter_stream_arbiter

Overview:
- Shares the single HLS Filter core between two 32-bit requester channel pairs.
- Each requester pair is an upstream read FIFO (data toward the filter) plus a downstream write FIFO (results).
- Grants the filter in bursts, round-robin, and routes filter output back to the owning requester.
- Sits between the Xillybus-facing FIFOs and Filter_0, all in the bus_clk domain.

Parameters:
- BURST_LEN, 64, maximum words fed to the filter per grant (1..1023).
- IDLE_TIMEOUT, 16, consecutive cycles of empty input that end a grant early (1..255).
- DRAIN_TIMEOUT, 4096, drain cycles allowed before the error flag is raised.

Ports:
- bus_clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_open  in  2  per-requester channel open; 0 = ineligible.
- req_in_data  in  2x32  upstream FIFO dout, requester i at [32i+31:32i].
- req_in_empty  in  2  upstream FIFO empty.
- req_in_rden  out  2  upstream FIFO rd_en.
- req_out_data  out  32  shared downstream data, driven with filter_outp_din.
- req_out_full  in  2  downstream FIFO full.
- req_out_wren  out  2  downstream FIFO wr_en.
- filter_inp_dout  out  32  to filter.
- filter_inp_empty_n  out  1  to filter.
- filter_inp_read  in  1  from filter.
- filter_outp_din  in  32  from filter.
- filter_outp_full_n  out  1  to filter.
- filter_outp_write  in  1  from filter.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  state != IDLE.
- err  out  1  sticky protocol/drain error.

Behaviour:
- Reset values:
  - state=IDLE, grant=00, rr_last=1 (requester 0 wins first), issued=0, returned=0, idle_cnt=0, drain_cnt=0.
  - busy=0, err=0; all rden/wren/empty_n/full_n outputs 0.
- Eligibility: eligible[i] = req_open[i] & !req_in_empty[i].
- IDLE:
  - If any requester is eligible, grant goes to the eligible one that is not rr_last (else the only eligible one).
  - Enter FEED next cycle; clear issued, returned, idle_cnt.
- FEED:
  - filter_inp_empty_n = !req_in_empty[g] & (issued < BURST_LEN).
  - filter_inp_dout = req_in_data[g].
  - req_in_rden[g] = filter_inp_read & filter_inp_empty_n; the other requester's rden is 0.
  - issued increments on each such read.
  - idle_cnt increments while req_in_empty[g] and clears otherwise.
  - Go to DRAIN when issued reaches BURST_LEN, when idle_cnt reaches IDLE_TIMEOUT, or when req_open[g] falls.
- DRAIN:
  - filter_inp_empty_n = 0.
  - When returned == issued, go to IDLE, set rr_last = g and grant = 00.
  - drain_cnt counts cycles in DRAIN; reaching DRAIN_TIMEOUT sets err and forces IDLE.
- Output path (FEED and DRAIN):
  - filter_outp_full_n = !req_out_full[g].
  - req_out_wren[g] = filter_outp_write & filter_outp_full_n.
  - returned increments on each such write.
- Output path (IDLE): filter_outp_full_n = 0 (backpressure); a filter_outp_write seen in IDLE sets err.
- Latency: combinational pass-through on all data/handshake paths; grant decision adds 1 cycle.
- Ownership switches only when returned == issued, so results never cross requesters. The filter is assumed to emit exactly one output word per input word.
- If returned would exceed issued: set err and ignore the excess.
- Simultaneous read and write in one cycle: both counters update independently.
- rst mid-burst: all state clears immediately. The external FIFOs and the filter are reset separately by the top level.
- Counter widths: issued/returned use $clog2(BURST_LEN+1) bits; they cannot wrap because they are bounded by BURST_LEN.

Optional Feature:
- Macro: FILTER_ARB_STATS_EN.
- With it:
  - Adds output stat_words (2x32), a per-requester count of words returned, wrapping at 2^32.
  - Adds output stat_grants (2x16), a per-requester grant count, saturating.
  - Both clear on rst, and both are readable through the Xillybus Lite register map.
- Without it: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package filter_arb_pkg holds:
  - the state enum (IDLE, FEED, DRAIN);
  - the requester count constant NREQ=2;
  - the counter width function.
- One sub-module, filter_arb_rr: 2-way round-robin picker taking eligible and rr_last, returning a one-hot grant.

Test Plan:
- Req0 alone with 100 words, BURST_LEN=64, filter modelled as a 3-cycle delay -> grants of 64 then 36 words, all outputs to req0 in order, err=0.
- Both requesters continuously eligible -> grant sequence 01,10,01,10; no req1 output word appears while grant=01.
- Req1 writes 10 words then goes empty, IDLE_TIMEOUT=16 -> DRAIN entered 16 cycles after the last read, then IDLE.
- req_out_full[0] held high for 50 cycles during DRAIN -> filter_outp_full_n=0 throughout; no data lost; returned reaches issued after release.
- Filter model drops 1 word, DRAIN_TIMEOUT=4096 -> err=1 after 4096 drain cycles; arbiter returns to IDLE and serves req1.
- Assert rst mid-FEED after 20 words -> next cycle grant=00, busy=0, all rden/wren=0; normal operation resumes after release.
